// File: rtl/count_seq_checker.sv
// count_seq_checker
// -----------------------------------------------------------------------------
// Watches the output bus of a small synchronous up/down counter. It learns the
// count direction from a run of consecutive legal steps, then flags every
// step that breaks the sequence (skip, stuck, reversal, spurious reset). It
// also flags legal wrap-arounds and keeps a saturating count of errors.
//
// Optional feature (macro CHECK_STICKY_EN):
//   Adds a sticky error flag that sets on any seq_err and is cleared by err_clr.
//   If both happen on the same edge, the set wins.
//
// Ports:
//   clk        in   rising-edge clock shared with the counter
//   reset      in   synchronous, active-high reset
//   q_in       in   [WIDTH-1:0] counter value being monitored
//   sample_en  in   q_in is sampled on this edge only when high
//   err_clr    in   (CHECK_STICKY_EN only) clears err_flag
//   err_flag   out  (CHECK_STICKY_EN only) sticky error indicator
//   locked     out  direction learned, checking active
//   dir_up     out  1 = up-counting, 0 = down; meaningful only while locked
//   seq_err    out  one-cycle pulse: illegal step while locked
//   wrap       out  one-cycle pulse: legal wrap while locked
//   err_count  out  [ERR_CNT_W-1:0] saturating count of seq_err pulses
// -----------------------------------------------------------------------------
module count_seq_checker #(
    parameter int WIDTH     = 3,
    parameter int LOCK_LEN  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     q_in,
    input  logic                 sample_en,
`ifdef CHECK_STICKY_EN
    input  logic                 err_clr,
    output logic                 err_flag,
`endif
    output logic                 locked,
    output logic                 dir_up,
    output logic                 seq_err,
    output logic                 wrap,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int STREAK_W = $clog2(LOCK_LEN + 1);
    localparam logic [WIDTH-1:0]     MAX_VAL = '1;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    prev;
    logic [STREAK_W-1:0] streak;
    logic                cand;

    logic [WIDTH-1:0]    delta;
    logic [WIDTH-1:0]    expected;
    logic                step_up;
    logic                step_down;
    logic [STREAK_W-1:0] streak_after;
    logic                step_error;

    // Modular difference between the new sample and the previous one. With a
    // 1-bit bus both directions give delta=1; treat that case as an up step.
    assign delta     = q_in - prev;
    assign step_up   = (delta == WIDTH'(1));
    assign step_down = (delta == MAX_VAL) && !step_up;

    // Value the counter must show next once the direction is known.
    assign expected  = dir_up ? (prev + WIDTH'(1)) : (prev - WIDTH'(1));

    // A legal step either extends the current run (same direction, or the
    // first step of a fresh run) or starts a new run of length one.
    assign streak_after = ((streak == '0) || (cand == step_up))
                        ? (streak + STREAK_W'(1))
                        : STREAK_W'(1);

    assign step_error = sample_en && (state == LOCKED) && (q_in != expected);

    // Main monitor FSM. Every output is a register updated on the same edge
    // that samples q_in; pulses are cleared by default each cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            prev      <= '0;
            streak    <= '0;
            cand      <= 1'b0;
            locked    <= 1'b0;
            dir_up    <= 1'b0;
            seq_err   <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            seq_err <= 1'b0;
            wrap    <= 1'b0;
            if (sample_en) begin
                prev <= q_in;
                case (state)
                    IDLE: begin
                        state  <= ACQUIRE;
                        streak <= '0;
                    end
                    ACQUIRE: begin
                        if (step_up || step_down) begin
                            cand   <= step_up;
                            streak <= streak_after;
                            if (streak_after == STREAK_W'(LOCK_LEN)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                                dir_up <= step_up;
                            end
                        end else if (delta != '0) begin
                            streak <= '0;
                        end
                    end
                    LOCKED: begin
                        if (!step_error) begin
                            wrap <= dir_up ? (q_in == '0) : (q_in == MAX_VAL);
                        end else begin
                            seq_err <= 1'b1;
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + ERR_CNT_W'(1);
                            end
                            state  <= ACQUIRE;
                            streak <= '0;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        streak <= '0;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CHECK_STICKY_EN
    // Sticky error flag: a new error takes priority over a clear request.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_flag <= 1'b0;
        end else if (step_error) begin
            err_flag <= 1'b1;
        end else if (err_clr) begin
            err_flag <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// tb_count_seq_checker
// -----------------------------------------------------------------------------
// Self-checking bench for count_seq_checker. Two instances share one stimulus
// stream: the default build and one with a 2-bit error counter, so saturation
// is observable. A reference model of the monitoring rules is advanced on each
// rising edge and compared against the DUT outputs on each falling edge.
// Directed sequences pin key literal values; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_count_seq_checker;

    localparam int LOCK_LEN = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       sample_en;
    logic [2:0] q_in;
    logic       err_clr;

    logic       locked,  dir_up,  seq_err,  wrap;
    logic [7:0] err_count;
    logic       locked2, dir_up2, seq_err2, wrap2;
    logic [1:0] err_count2;
`ifdef CHECK_STICKY_EN
    logic       err_flag, err_flag2;
`endif

    int checks = 0;
    int errors = 0;
    int lastq  = 0;

    // Reference model state
    bit started = 1'b0;
    int m_mode, m_prev, m_streak, m_errs;
    bit m_cand, m_locked, m_dir, m_seq, m_wrap, m_flag;

    always #5 clk = ~clk;

    count_seq_checker #(.WIDTH(3), .LOCK_LEN(LOCK_LEN), .ERR_CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .q_in      (q_in),
        .sample_en (sample_en),
`ifdef CHECK_STICKY_EN
        .err_clr   (err_clr),
        .err_flag  (err_flag),
`endif
        .locked    (locked),
        .dir_up    (dir_up),
        .seq_err   (seq_err),
        .wrap      (wrap),
        .err_count (err_count)
    );

    count_seq_checker #(.WIDTH(3), .LOCK_LEN(LOCK_LEN), .ERR_CNT_W(2)) dut2 (
        .clk       (clk),
        .reset     (reset),
        .q_in      (q_in),
        .sample_en (sample_en),
`ifdef CHECK_STICKY_EN
        .err_clr   (err_clr),
        .err_flag  (err_flag2),
`endif
        .locked    (locked2),
        .dir_up    (dir_up2),
        .seq_err   (seq_err2),
        .wrap      (wrap2),
        .err_count (err_count2)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; returns shortly after the following falling edge,
    // once the compare process has looked at the outputs.
    task automatic applyStimulus(input bit r, input bit en, input int q, input bit clr = 1'b0);
        reset     = r;
        sample_en = en;
        q_in      = 3'(q);
        err_clr   = clr;
        @(posedge clk);
        @(negedge clk);
        #2;
        if (r) lastq = 0;
        else if (en) lastq = q & 7;
    endtask

    // Reference model: applies the monitoring rules to the inputs seen at the
    // rising edge, working on plain integers modulo 8.
    always @(posedge clk) begin : model
        int d;
        int e;
        bit up;
        started = 1'b1;
        if (reset) begin
            m_mode = 0; m_prev = 0; m_streak = 0; m_cand = 0;
            m_locked = 0; m_dir = 0; m_seq = 0; m_wrap = 0;
            m_errs = 0; m_flag = 0;
        end else begin
            m_seq  = 0;
            m_wrap = 0;
            if (sample_en) begin
                d = (int'(q_in) - m_prev + 8) % 8;
                if (m_mode == 0) begin
                    m_mode   = 1;
                    m_streak = 0;
                end else if (m_mode == 1) begin
                    if (d == 1 || d == 7) begin
                        up = (d == 1);
                        if (m_streak == 0 || m_cand == up) m_streak++;
                        else m_streak = 1;
                        m_cand = up;
                        if (m_streak == LOCK_LEN) begin
                            m_mode   = 2;
                            m_locked = 1;
                            m_dir    = up;
                        end
                    end else if (d != 0) begin
                        m_streak = 0;
                    end
                end else begin
                    e = m_dir ? (m_prev + 1) % 8 : (m_prev + 7) % 8;
                    if (int'(q_in) == e) begin
                        m_wrap = m_dir ? (q_in == 3'd0) : (q_in == 3'd7);
                    end else begin
                        m_seq    = 1;
                        m_errs++;
                        m_mode   = 1;
                        m_streak = 0;
                        m_locked = 0;
                    end
                end
                m_prev = int'(q_in);
            end
            if (m_seq) m_flag = 1;
            else if (err_clr) m_flag = 0;
        end
    end

    // Compare process: every cycle after the first edge.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("locked",     locked,     m_locked);
            checkOutput("dir_up",     dir_up,     m_dir);
            checkOutput("seq_err",    seq_err,    m_seq);
            checkOutput("wrap",       wrap,       m_wrap);
            checkOutput("err_count",  err_count,  (m_errs > 255) ? 255 : m_errs);
            checkOutput("locked2",    locked2,    m_locked);
            checkOutput("seq_err2",   seq_err2,   m_seq);
            checkOutput("err_count2", err_count2, (m_errs > 3) ? 3 : m_errs);
`ifdef CHECK_STICKY_EN
            checkOutput("err_flag",   err_flag,   m_flag);
            checkOutput("err_flag2",  err_flag2,  m_flag);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p;
        int q;
        int kind;
        bit rdir;
        bit r;
        bit en;

        reset = 1'b1; sample_en = 1'b0; q_in = 3'd0; err_clr = 1'b0;
        @(negedge clk);
        #2;
        applyStimulus(1, 0, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_err_count", err_count, 0);

        // Up count, lock on the sample of 2, wrap on 7->0
        for (int i = 0; i <= 2; i++) applyStimulus(0, 1, i);
        checkOutput("up_locked", locked, 1);
        checkOutput("up_dir", dir_up, 1);
        for (int i = 3; i <= 7; i++) applyStimulus(0, 1, i);
        checkOutput("up_nowrap", wrap, 0);
        applyStimulus(0, 1, 0);
        checkOutput("up_wrap", wrap, 1);
        applyStimulus(0, 1, 1);
        checkOutput("up_wrap_once", wrap, 0);
        checkOutput("up_still_locked", locked, 1);

        // Down count from 5, lock on 3, wrap on 0->7
        applyStimulus(1, 0, 0);
        applyStimulus(0, 1, 5);
        applyStimulus(0, 1, 4);
        applyStimulus(0, 1, 3);
        checkOutput("dn_locked", locked, 1);
        checkOutput("dn_dir", dir_up, 0);
        applyStimulus(0, 1, 2);
        applyStimulus(0, 1, 1);
        applyStimulus(0, 1, 0);
        applyStimulus(0, 1, 7);
        checkOutput("dn_wrap", wrap, 1);

        // Reversal while locked up, then relock downward
        applyStimulus(1, 0, 0);
        for (int i = 0; i <= 4; i++) applyStimulus(0, 1, i);
        applyStimulus(0, 1, 3);
        checkOutput("rev_seq_err", seq_err, 1);
        checkOutput("rev_err_count", err_count, 1);
        checkOutput("rev_unlocked", locked, 0);
        applyStimulus(0, 1, 2);
        applyStimulus(0, 1, 1);
        checkOutput("rev_relocked", locked, 1);
        checkOutput("rev_dir", dir_up, 0);

        // Five more errors, each followed by a downward relock
        for (int k = 0; k < 5; k++) begin
            p = lastq;
            applyStimulus(0, 1, (p + 3) & 7);
            applyStimulus(0, 1, (lastq + 7) & 7);
            applyStimulus(0, 1, (lastq + 7) & 7);
        end
        checkOutput("sat_err_count2", err_count2, 3);
        checkOutput("sat_err_count", err_count, 6);
        checkOutput("sat_locked", locked, 1);

        // sample_en low: q_in moves, nothing changes
        for (int k = 0; k < 3; k++) begin
            applyStimulus(0, 0, (lastq + 2 + k) & 7);
            checkOutput("hold_locked", locked, 1);
            checkOutput("hold_seq_err", seq_err, 0);
            checkOutput("hold_err_count", err_count, 6);
        end
        applyStimulus(0, 1, (lastq + 7) & 7);
        checkOutput("hold_resume_ok", seq_err, 0);

        // Reset while locked with err_count=2
        applyStimulus(1, 0, 0);
        for (int i = 0; i <= 2; i++) applyStimulus(0, 1, i);
        applyStimulus(0, 1, 5);
        applyStimulus(0, 1, 6);
        applyStimulus(0, 1, 7);
        applyStimulus(0, 1, 3);
        applyStimulus(0, 1, 4);
        applyStimulus(0, 1, 5);
        checkOutput("pre_rst_err_count", err_count, 2);
        checkOutput("pre_rst_locked", locked, 1);
        applyStimulus(1, 1, 6);
        checkOutput("mid_rst_locked", locked, 0);
        checkOutput("mid_rst_err_count", err_count, 0);
        applyStimulus(0, 1, 3);
        checkOutput("idle_no_err", seq_err, 0);
        checkOutput("idle_not_locked", locked, 0);

`ifdef CHECK_STICKY_EN
        applyStimulus(1, 0, 0);
        for (int i = 0; i <= 2; i++) applyStimulus(0, 1, i);
        applyStimulus(0, 1, 7);
        checkOutput("sticky_set", err_flag, 1);
        applyStimulus(0, 1, 0, 1);
        checkOutput("sticky_clr", err_flag, 0);
        applyStimulus(0, 1, 1);
        applyStimulus(0, 1, 6, 1);
        checkOutput("sticky_set_wins", err_flag, 1);
`endif

        // Randomized phase: mostly legal counting with occasional faults
        rdir = 1'b1;
        for (int n = 0; n < 800; n++) begin
            r    = ($urandom_range(0, 99) == 0);
            en   = ($urandom_range(0, 9) != 0);
            kind = $urandom_range(0, 19);
            if (kind == 0) begin
                q = lastq;
            end else if (kind == 1) begin
                q = $urandom_range(0, 7);
            end else if (kind == 2) begin
                rdir = ~rdir;
                q = rdir ? (lastq + 1) & 7 : (lastq + 7) & 7;
            end else if (kind == 3) begin
                q = 0;
            end else begin
                q = rdir ? (lastq + 1) & 7 : (lastq + 7) & 7;
            end
            applyStimulus(r, en, q, ($urandom_range(0, 7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
